// File: rtl/crypto_fu_arbiter.sv
// Two-requester round-robin front end for the shared scalar crypto FU.
// One operation in flight; decodes the 5-bit opcode to one-hot strobes,
// holds operands stable while the FU runs, and bounds the wait with a timeout.
module crypto_fu_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_op,
   input  logic [31:0] req0_rs1,
   input  logic [31:0] req0_rs2,
   input  logic [1:0]  req0_imm,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_op,
   input  logic [31:0] req1_rs1,
   input  logic [31:0] req1_rs2,
   input  logic [1:0]  req1_imm,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_rd,
   output logic        rsp0_err,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_rd,
   output logic        rsp1_err,
   output logic        fu_valid,
   output logic [20:0] fu_op,
   output logic [31:0] fu_rs1,
   output logic [31:0] fu_rs2,
   output logic [1:0]  fu_imm,
   input  logic        fu_ready,
   input  logic [31:0] fu_rd
);

   localparam int unsigned NUM_OPS = 21;
   localparam int unsigned OP_W    = 5;
   localparam int unsigned XLEN    = 32;
   localparam int unsigned IMM_W   = 2;
   localparam int unsigned CNT_W   = 8;
   localparam logic [OP_W-1:0]  LAST_OP  = OP_W'(NUM_OPS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, owner_q, err_q;
   logic [OP_W-1:0]   op_q;
   logic [XLEN-1:0]   rs1_q, rs2_q, rd_q;
   logic [IMM_W-1:0]  imm_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              grant_c, legal_c, accept_c, own_ready_c, timeout_c, busy_c, resp_c;
   logic [OP_W-1:0]   sel_op_c;
   logic [XLEN-1:0]   sel_rs1_c, sel_rs2_c;
   logic [IMM_W-1:0]  sel_imm_c;

   // Round-robin pick (ties go to the requester not granted last) and operand mux
   always_comb begin
      grant_c = req1_valid;
      if (req0_valid && req1_valid) grant_c = ~last_grant_q;
      sel_op_c  = grant_c ? req1_op  : req0_op;
      sel_rs1_c = grant_c ? req1_rs1 : req0_rs1;
      sel_rs2_c = grant_c ? req1_rs2 : req0_rs2;
      sel_imm_c = grant_c ? req1_imm : req0_imm;
      legal_c   = (sel_op_c <= LAST_OP);
   end

   // Next-state logic and same-cycle request acceptance
   always_comb begin
      state_d     = state_q;
      accept_c    = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      own_ready_c = owner_q ? rsp1_ready : rsp0_ready;
      timeout_c   = (cnt_q == CNT_LAST);
      case (state_q)
         ST_IDLE: begin
            if (req0_valid || req1_valid) begin
               accept_c   = 1'b1;
               req0_ready = ~grant_c;
               req1_ready = grant_c;
               state_d    = legal_c ? ST_BUSY : ST_RESP;
            end
         end
         ST_BUSY: if (fu_ready || timeout_c) state_d = ST_RESP;
         ST_RESP: if (own_ready_c) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Request capture, timeout counter, result latch and round-robin pointer
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         op_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         imm_q        <= '0;
         cnt_q        <= '0;
         rd_q         <= '0;
         err_q        <= 1'b0;
      end else begin
         if (accept_c) begin
            owner_q <= grant_c;
            op_q    <= sel_op_c;
            rs1_q   <= sel_rs1_c;
            rs2_q   <= sel_rs2_c;
            imm_q   <= sel_imm_c;
            cnt_q   <= '0;
            if (!legal_c) begin
               err_q <= 1'b1;
               rd_q  <= '0;
            end
         end
         if (state_q == ST_BUSY) begin
            if (fu_ready) begin
               rd_q  <= fu_rd;
               err_q <= 1'b0;
            end else if (timeout_c) begin
               rd_q  <= '0;
               err_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         if (state_q == ST_RESP && own_ready_c) last_grant_q <= owner_q;
      end
   end

   // FU drive and response outputs, decoded from registered state only
   always_comb begin
      busy_c     = (state_q == ST_BUSY);
      resp_c     = (state_q == ST_RESP);
      fu_valid   = busy_c;
      fu_op      = '0;
      fu_rs1     = '0;
      fu_rs2     = '0;
      fu_imm     = '0;
      if (busy_c) begin
         fu_op  = NUM_OPS'(1) << op_q;
         fu_rs1 = rs1_q;
         fu_rs2 = rs2_q;
         fu_imm = imm_q;
      end
      rsp0_valid = resp_c && !owner_q;
      rsp1_valid = resp_c && owner_q;
      rsp0_rd    = rsp0_valid ? rd_q  : '0;
      rsp1_rd    = rsp1_valid ? rd_q  : '0;
      rsp0_err   = rsp0_valid ? err_q : 1'b0;
      rsp1_err   = rsp1_valid ? err_q : 1'b0;
   end

endmodule
